data_cache: RTL and testbench

Two-way set-associative, write-through, no-write-allocate data cache placed between the MEM stage and the SRAM controller of the pipelined MIPS. It serves read hits in the request cycle, and on a read miss fetches a 64-bit line (two words) through the SRAM controller. Every write is forwarded to SRAM. It drives a `ready` signal that the hazard/freeze logic uses to stall the pipeline while a request is outstanding.

---
 rtl/cache_pkg.sv | 33 +++
 rtl/cache_way.sv | 51 +++++
 rtl/data_cache.sv | 166 ++++++++++++++++
 tb/tb_data_cache.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared constants, FSM state encoding and address field helpers for the
// two-way set-associative write-through data cache.
package cache_pkg;

    localparam int BASE_ADDR = 1024;
    localparam int SETS      = 64;
    localparam int IW        = $clog2(SETS);
    localparam int TAG_W     = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WRITE = 2'd2
    } state_t;

    function automatic logic [31:0] addr_off(input logic [31:0] address, input int base);
        return address - 32'(base);
    endfunction

    // Line index sits just above the 8-byte line offset.
    function automatic logic [31:0] addr_index(input logic [31:0] off, input int iw);
        return (off >> 3) & ((32'd1 << iw) - 32'd1);
    endfunction

    function automatic logic addr_word(input logic [31:0] off);
        return off[2];
    endfunction

    function automatic logic [31:0] addr_tag(input logic [31:0] off, input int iw, input int tag_w);
        return (off >> (3 + iw)) & ((32'd1 << tag_w) - 32'd1);
    endfunction

endpackage

// File: rtl/cache_way.sv
// One way of the cache: valid bits, tags and 64-bit lines per set, with a
// full-line fill port and a single-word write port.
module cache_way #(
    parameter int SETS  = 64,
    parameter int IW    = 6,
    parameter int TAG_W = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IW-1:0]    index,
    output logic             valid,
    output logic [TAG_W-1:0] tag,
    output logic [63:0]      line,
    input  logic             fill,
    input  logic [TAG_W-1:0] fill_tag,
    input  logic [63:0]      fill_line,
    input  logic             word_wr,
    input  logic             word_sel,
    input  logic [31:0]      word_data
);

    logic             valid_q [SETS];
    logic [TAG_W-1:0] tag_q   [SETS];
    logic [63:0]      data_q  [SETS];

    assign valid = valid_q[index];
    assign tag   = tag_q[index];
    assign line  = data_q[index];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SETS; i++) valid_q[i] <= 1'b0;
        end else if (fill) begin
            valid_q[index] <= 1'b1;
        end
    end

    // Tag and data need no reset; the valid bit alone qualifies them.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (fill) begin
                tag_q[index]  <= fill_tag;
                data_q[index] <= fill_line;
            end else if (word_wr) begin
                if (word_sel) data_q[index][63:32] <= word_data;
                else          data_q[index][31:0]  <= word_data;
            end
        end
    end

endmodule

// File: rtl/data_cache.sv
// Two-way set-associative, write-through, no-write-allocate data cache with
// LRU replacement, sitting between the MEM stage and the SRAM controller.
module data_cache #(
    parameter int BASE_ADDR = cache_pkg::BASE_ADDR,
    parameter int SETS      = cache_pkg::SETS,
    parameter int TAG_W     = cache_pkg::TAG_W
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rd_en,
    input  logic        wr_en,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready,
    output logic        sram_rd_en,
    output logic        sram_wr_en,
    output logic [31:0] sram_address,
    output logic [31:0] sram_write_data,
    input  logic [63:0] sram_read_data,
    input  logic        sram_ready
);

    import cache_pkg::*;

    localparam int IW = $clog2(SETS);

    state_t state, state_next;

    logic [31:0]      off;
    logic [IW-1:0]    index;
    logic             word;
    logic [TAG_W-1:0] tag;

    logic [1:0]       way_valid;
    logic [TAG_W-1:0] way_tag  [2];
    logic [63:0]      way_line [2];
    logic [1:0]       way_fill;
    logic [1:0]       way_word_wr;

    logic             lru_q [SETS];
    logic             lru_upd;
    logic             lru_val;

    logic             hit0, hit1, hit, hit_way, victim, fill_done;
    logic [63:0]      hit_line;

    assign off   = addr_off(address, BASE_ADDR);
    assign index = IW'(addr_index(off, IW));
    assign word  = addr_word(off);
    assign tag   = TAG_W'(addr_tag(off, IW, TAG_W));

    assign sram_address    = address;
    assign sram_write_data = write_data;

    for (genvar w = 0; w < 2; w++) begin : g_way
        cache_way #(.SETS(SETS), .IW(IW), .TAG_W(TAG_W)) u_way (
            .clk       (clk),
            .rst       (rst),
            .index     (index),
            .valid     (way_valid[w]),
            .tag       (way_tag[w]),
            .line      (way_line[w]),
            .fill      (way_fill[w]),
            .fill_tag  (tag),
            .fill_line (sram_read_data),
            .word_wr   (way_word_wr[w]),
            .word_sel  (word),
            .word_data (write_data)
        );
    end

    assign hit0     = way_valid[0] && (way_tag[0] == tag);
    assign hit1     = way_valid[1] && (way_tag[1] == tag) && !hit0;
    assign hit      = hit0 || hit1;
    assign hit_way  = hit1;
    assign hit_line = hit_way ? way_line[1] : way_line[0];

    // Prefer an empty way (way 0 first); otherwise evict the LRU way.
    assign victim = !way_valid[0] ? 1'b0 :
                    !way_valid[1] ? 1'b1 : lru_q[index];

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SETS; i++) lru_q[i] <= 1'b0;
        end else if (lru_upd) begin
            lru_q[index] <= lru_val;
        end
    end

    // Everything is forced quiet during reset so a pending fill cannot land.
    always_comb begin
        state_next  = state;
        ready       = 1'b0;
        read_data   = 32'd0;
        sram_rd_en  = 1'b0;
        sram_wr_en  = 1'b0;
        way_fill    = 2'b00;
        way_word_wr = 2'b00;
        lru_upd     = 1'b0;
        lru_val     = 1'b0;
        fill_done   = 1'b0;
        if (!rst) begin
            case (state)
                IDLE: begin
                    if (wr_en) begin
                        sram_wr_en = 1'b1;
                        state_next = WRITE;
                    end else if (rd_en) begin
                        if (hit) begin
                            ready     = 1'b1;
                            read_data = word ? hit_line[63:32] : hit_line[31:0];
                            lru_upd   = 1'b1;
                            lru_val   = ~hit_way;
                        end else begin
                            sram_rd_en = 1'b1;
                            if (sram_ready) fill_done  = 1'b1;
                            else            state_next = FILL;
                        end
                    end
                end
                FILL: begin
                    if (!rd_en) begin
                        state_next = IDLE;
                    end else begin
                        sram_rd_en = 1'b1;
                        if (sram_ready) begin
                            fill_done  = 1'b1;
                            state_next = IDLE;
                        end
                    end
                end
                WRITE: begin
                    if (!wr_en) begin
                        state_next = IDLE;
                    end else begin
                        sram_wr_en = 1'b1;
                        if (sram_ready) begin
                            ready      = 1'b1;
                            state_next = IDLE;
                            if (hit) begin
                                way_word_wr[hit_way] = 1'b1;
                                lru_upd              = 1'b1;
                                lru_val              = ~hit_way;
                            end
                        end
                    end
                end
                default: state_next = IDLE;
            endcase
            if (fill_done) begin
                way_fill[victim] = 1'b1;
                lru_upd          = 1'b1;
                lru_val          = ~victim;
                ready            = 1'b1;
                read_data        = word ? sram_read_data[63:32] : sram_read_data[31:0];
            end
        end
    end

endmodule

// File: tb/tb_data_cache.sv
// Scoreboard bench for data_cache: a recency-list cache model and an SRAM
// model with random latency predict hit/miss and load data per request.
module tb_data_cache;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rd_en = 1'b0;
    logic        wr_en = 1'b0;
    logic [31:0] address = 32'd0;
    logic [31:0] write_data = 32'd0;
    logic [31:0] read_data;
    logic        ready;
    logic        sram_rd_en;
    logic        sram_wr_en;
    logic [31:0] sram_address;
    logic [31:0] sram_write_data;
    logic [63:0] sram_read_data = 64'd0;
    logic        sram_ready = 1'b0;

    data_cache dut (
        .clk             (clk),
        .rst             (rst),
        .rd_en           (rd_en),
        .wr_en           (wr_en),
        .address         (address),
        .write_data      (write_data),
        .read_data       (read_data),
        .ready           (ready),
        .sram_rd_en      (sram_rd_en),
        .sram_wr_en      (sram_wr_en),
        .sram_address    (sram_address),
        .sram_write_data (sram_write_data),
        .sram_read_data  (sram_read_data),
        .sram_ready      (sram_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_write;
        bit          hit;
        logic [31:0] data;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] recency[$];
    logic [31:0] mem [int unsigned];
    int          n_vec = 0;
    int          n_err = 0;
    int          force_lat = 0;
    int          sram_cnt = 0;
    int          lat_now = 1;
    bit          saw_rd = 0, saw_wr = 0, saw_both = 0;

    function automatic logic [31:0] mem_read(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return a * 32'h9E3779B1;
    endfunction

    function automatic int set_of(input logic [31:0] line);
        return int'(((line - 32'd1024) >> 3) & 32'd63);
    endfunction

    function automatic bit model_has(input logic [31:0] line);
        foreach (recency[i]) if (recency[i] == line) return 1'b1;
        return 1'b0;
    endfunction

    function automatic void model_touch(input logic [31:0] line);
        for (int i = 0; i < recency.size(); i++)
            if (recency[i] == line) begin recency.delete(i); break; end
        recency.push_back(line);
    endfunction

    // A full set loses its least recently used line (earliest in the list).
    function automatic void model_fill(input logic [31:0] line);
        int n = 0;
        foreach (recency[i]) if (set_of(recency[i]) == set_of(line)) n++;
        if (n >= 2)
            for (int i = 0; i < recency.size(); i++)
                if (set_of(recency[i]) == set_of(line)) begin recency.delete(i); break; end
        recency.push_back(line);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // SRAM controller model: completes a held request after 1..4 cycles.
    always @(posedge clk) begin
        if (rst || sram_ready || !(sram_rd_en || sram_wr_en)) begin
            if (!rst && sram_ready && sram_wr_en) mem[sram_address] = sram_write_data;
            sram_cnt   <= 0;
            sram_ready <= 1'b0;
        end else begin
            if (sram_cnt == 0) lat_now = (force_lat != 0) ? force_lat : int'($urandom_range(1, 4));
            sram_cnt <= sram_cnt + 1;
            if (sram_cnt + 1 == lat_now) begin
                sram_ready     <= 1'b1;
                sram_read_data <= {mem_read({sram_address[31:3], 3'b100}),
                                   mem_read({sram_address[31:3], 3'b000})};
            end
        end
    end

    // Monitor: pops one expectation per completed access.
    always @(negedge clk) begin
        if (rst || (!rd_en && !wr_en)) begin
            saw_rd = 0; saw_wr = 0; saw_both = 0;
        end else begin
            saw_rd   = saw_rd | sram_rd_en;
            saw_wr   = saw_wr | sram_wr_en;
            saw_both = saw_both | (sram_rd_en & sram_wr_en);
            if (ready) begin
                if (exp_q.size() == 0) begin
                    n_vec++; n_err++;
                    $display("[TB] FAIL unexpected_ready: got ready=1 expected no access pending");
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (e.is_write) begin
                        checkOutput("write_path", {30'd0, saw_wr, saw_rd}, 32'd2);
                    end else begin
                        checkOutput("read_data", read_data, e.data);
                        checkOutput("read_hit", {31'd0, !saw_rd}, {31'd0, e.hit});
                    end
                    checkOutput("enable_overlap", {31'd0, saw_both}, 32'd0);
                end
                saw_rd = 0; saw_wr = 0; saw_both = 0;
            end
        end
    end

    task automatic applyStimulus(input bit wr, input bit rd, input logic [31:0] addr, input logic [31:0] data);
        exp_t        e;
        logic [31:0] line;
        bit          done;
        @(posedge clk); #1;
        line       = {addr[31:3], 3'b000};
        e.is_write = wr;
        e.hit      = model_has(line);
        e.data     = wr ? 32'd0 : mem_read(addr);
        if (e.hit)    model_touch(line);
        else if (!wr) model_fill(line);
        exp_q.push_back(e);
        wr_en = wr; rd_en = rd; address = addr; write_data = data;
        done = 0;
        for (int i = 0; i < 64 && !done; i++) begin
            @(negedge clk);
            done = ready;
        end
        if (!done) begin
            n_vec++; n_err++;
            $display("[TB] FAIL timeout addr %h: ready stayed 0, expected 1", addr);
            exp_q.delete();
        end
    endtask

    task automatic idleCycle();
        @(posedge clk); #1;
        rd_en = 0; wr_en = 0;
    endtask

    initial begin
        rd_en = 1; address = 32'd1024;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_ready", {31'd0, ready}, 32'd0);
        checkOutput("rst_sram_rd_en", {31'd0, sram_rd_en}, 32'd0);
        checkOutput("rst_sram_wr_en", {31'd0, sram_wr_en}, 32'd0);
        checkOutput("rst_read_data", read_data, 32'd0);
        @(posedge clk); #1;
        rst = 0; rd_en = 0;

        mem[32'd1024] = 32'h11111111;
        mem[32'd1028] = 32'h22222222;
        applyStimulus(0, 1, 32'd1024, 32'd0);
        applyStimulus(0, 1, 32'd1028, 32'd0);

        // Index 0, tags A (1024), B (1536), C (2048): C must evict B.
        applyStimulus(0, 1, 32'd1536, 32'd0);
        applyStimulus(0, 1, 32'd1024, 32'd0);
        applyStimulus(0, 1, 32'd2048, 32'd0);
        applyStimulus(0, 1, 32'd1024, 32'd0);
        applyStimulus(0, 1, 32'd1536, 32'd0);

        applyStimulus(1, 0, 32'd1028, 32'hDEADBEEF);
        applyStimulus(0, 1, 32'd1028, 32'd0);
        applyStimulus(0, 1, 32'd1024, 32'd0);

        applyStimulus(1, 0, 32'd2576, 32'h12345678);
        applyStimulus(0, 1, 32'd2576, 32'd0);

        applyStimulus(1, 1, 32'd1032, 32'hCAFEF00D);
        applyStimulus(0, 1, 32'd1032, 32'd0);
        idleCycle();

        // Dropped request mid-fill.
        @(posedge clk); #1;
        force_lat = 20; rd_en = 1; wr_en = 0; address = 32'd3072;
        @(posedge clk);
        @(posedge clk); #1;
        rd_en = 0;
        @(negedge clk);
        checkOutput("flush_sram_rd_en", {31'd0, sram_rd_en}, 32'd0);
        @(posedge clk); #1;
        force_lat = 0;
        applyStimulus(0, 1, 32'd3072, 32'd0);
        idleCycle();

        // Reset two cycles into a fill.
        @(posedge clk); #1;
        force_lat = 20; rd_en = 1; address = 32'd3584;
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1;
        @(negedge clk);
        checkOutput("rst_fill_sram_rd_en", {31'd0, sram_rd_en}, 32'd0);
        @(posedge clk); #1;
        rst = 0; rd_en = 0; force_lat = 0;
        recency.delete();
        @(negedge clk);
        checkOutput("post_rst_sram_rd_en", {31'd0, sram_rd_en}, 32'd0);
        applyStimulus(0, 1, 32'd3584, 32'd0);
        applyStimulus(0, 1, 32'd1024, 32'd0);

        for (int n = 0; n < 300; n++) begin
            logic [31:0] a;
            int          op;
            a  = 32'd1024 + 32'($urandom_range(0, 3)) * 32'd512
                          + 32'($urandom_range(0, 1)) * 32'd8
                          + 32'($urandom_range(0, 1)) * 32'd4;
            op = int'($urandom_range(0, 9));
            if (op < 6)      applyStimulus(0, 1, a, 32'd0);
            else if (op < 9) applyStimulus(1, 0, a, $urandom);
            else             applyStimulus(1, 1, a, $urandom);
            if ($urandom_range(0, 3) == 0) idleCycle();
        end
        idleCycle();
        repeat (3) @(posedge clk);
        checkOutput("pending_expectations", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
